dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Memory-side responder for the single-cycle RISC-V core's data port.
- Takes the core's address (alu_result), write_data and mem_write, and returns read_data in the same cycle.
- Contains a word data RAM, a console TX FIFO with a valid/ready drain port, a cycle counter and a tohost/halt register.
- Sits beside the core in the system top, opposite the core's data-memory interface.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 8, console TX FIFO entries; power of 2, at least 2.
- MMIO_BASE, 32'hFFFF_0000, base address of the MMIO window; low 16 bits are zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the core (alu_result); addr[1:0] ignored.
- write_data  in  32  store data from the core.
- mem_write  in  1  store strobe; sampled on the rising edge.
- read_data  out  32  load data; combinational from addr and current state.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts the head byte when tx_valid and tx_ready are both high at the edge.
- halted  out  1  set by a write to TOHOST.

Behaviour:
- Address decode:
  - RAM hit: addr < RAM_WORDS*4; word index is addr[log2(RAM_WORDS)+1:2].
  - MMIO hit: addr[31:16] == MMIO_BASE[31:16], register selected by addr[3:2]:
    - offset 0x0 CONSOLE: write pushes write_data[7:0]; read returns the FIFO count, zero-extended.
    - offset 0x4 STATUS: read-only. bit0 full, bit1 empty, bit2 halted, bit3 overflow (sticky), other bits 0.
    - offset 0x8 CYCLE: read returns the counter; write loads write_data.
    - offset 0xC TOHOST: write latches write_data and sets halted; read returns the latched value.
  - Any other address: read_data = 0; writes ignored with no side effects.
- Reads: zero latency, purely combinational. A read never changes state; reading CONSOLE does not pop.
- Writes: take effect at the rising edge where mem_write = 1. A RAM read-after-write to the same address in the next cycle returns the new data.
- RAM:
  - No reset of contents.
  - Simulation initial contents are 0.
  - No byte enables; all stores are full-word.
- FIFO:
  - Push accepted when not full, or when full and a pop occurs in the same cycle.
  - A push that is not accepted drops the byte and sets overflow (sticky until reset).
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - A push into an empty FIFO raises tx_valid on the next cycle; tx_data is the oldest entry.
  - Read and write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH and needs log2(FIFO_DEPTH)+1 bits.
- CYCLE counter:
  - Increments by 1 each cycle while halted = 0; wraps 0xFFFF_FFFF -> 0.
  - A write in the same cycle wins: counter <= write_data. Increment resumes the following cycle.
  - Frozen while halted = 1; writes still load it.
- TOHOST / halted:
  - halted goes high the cycle after a TOHOST write and stays high until reset.
  - A later TOHOST write updates the latched value.
  - FIFO draining continues while halted.
- Reset (synchronous, reachable mid-operation):
  - FIFO pointers and count -> 0, tx_valid = 0, overflow = 0.
  - CYCLE = 0, TOHOST value = 0, halted = 0.
  - RAM is untouched.
  - A mem_write in the same cycle as reset is ignored.
  - Entries in flight are discarded.
- Reset values of outputs: tx_valid 0, halted 0, tx_data 0.
  - read_data follows decode: RAM word, MMIO value after reset, or 0 for unmapped.

Test Plan:
- RAM: store 0xDEADBEEF to 0x10, then load 0x10 and 0x13 -> both return 0xDEADBEEF in the cycle after the store; load 0x0008_0000 -> 0.
- Console ordering: push 'H','i' with tx_ready = 0 -> CONSOLE reads 2, STATUS bit1 = 0. Raise tx_ready -> tx_data 0x48 then 0x69 on consecutive edges, then tx_valid = 0 and STATUS = 0x2.
- Full/overflow: with tx_ready = 0, push 9 bytes (depth 8) -> STATUS = 0x9 (full + overflow), 9th byte lost. Push while full with tx_ready = 1 in the same cycle -> accepted, count stays 8.
- CYCLE: after reset, read on cycle 5 -> 5. Write 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0 on successive cycles.
- Halt: write 1 to TOHOST -> halted = 1 next cycle, TOHOST reads 1, CYCLE constant for 10 cycles, FIFO still drains.
- Reset mid-operation: assert reset with 3 bytes queued and mem_write high to CONSOLE -> next cycle count 0, tx_valid 0, halted 0, CYCLE 0; RAM contents preserved.

Source files
------------

// File: rtl/dmem_mmio_responder_if.sv
// Data-port bundle between the single-cycle core and dmem_mmio_responder.
// Carries the core's load/store signals plus the console TX drain port.
//   addr       : byte address from the core (alu_result)
//   write_data : store data
//   mem_write  : store strobe
//   read_data  : combinational load data
//   tx_data    : console FIFO head byte
//   tx_valid   : console FIFO not empty
//   tx_ready   : console consumer accepts the head byte
//   halted     : set once the program writes TOHOST
// master = core/system side, slave = the responder.
interface dmem_mmio_responder_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halted;

  modport master (
    output addr, write_data, mem_write, tx_ready,
    input  read_data, tx_data, tx_valid, halted
  );

  modport slave (
    input  addr, write_data, mem_write, tx_ready,
    output read_data, tx_data, tx_valid, halted
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Memory-side responder for the single-cycle RISC-V core's data port.
// Decodes the core address into a word RAM and a small MMIO window:
//   +0x0 CONSOLE : write pushes a byte into the TX FIFO, read returns count
//   +0x4 STATUS  : {overflow, halted, empty, full} in bits 3..0
//   +0x8 CYCLE   : free-running cycle counter, writable, frozen when halted
//   +0xC TOHOST  : write latches value and halts, read returns latched value
// Loads are combinational; stores and FIFO pops take effect on posedge clk.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (RAM contents are kept)
//   bus   : data port and console drain port (slave modport)
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input logic                    clk,
  input logic                    reset,
  dmem_mmio_responder_if.slave   bus
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    REG_CONSOLE = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CYCLE   = 2'd2,
    REG_TOHOST  = 2'd3
  } mmio_reg_e;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              ram_hit;
  logic              mmio_hit;
  mmio_reg_e         reg_sel;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit  = (bus.addr[31:RAM_AW+2] == '0);
  assign mmio_hit = (bus.addr[31:16] == MMIO_BASE[31:16]);
  assign reg_sel  = mmio_reg_e'(bus.addr[3:2]);
  assign ram_idx  = bus.addr[RAM_AW+1:2];

  // Byte offset within a word is irrelevant: all accesses are full-word.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

  // A store coinciding with reset is dropped entirely.
  logic wr_en;
  logic ram_we;
  logic mmio_we;
  logic push_req;
  logic cycle_we;
  logic tohost_we;

  assign wr_en     = bus.mem_write && !reset;
  assign ram_we    = wr_en && ram_hit;
  assign mmio_we   = wr_en && mmio_hit && !ram_hit;
  assign push_req  = mmio_we && (reg_sel == REG_CONSOLE);
  assign cycle_we  = mmio_we && (reg_sel == REG_CYCLE);
  assign tohost_we = mmio_we && (reg_sel == REG_TOHOST);

  // ---------------------------------------------------------------------
  // Data RAM (no reset, contents survive a core reset)
  // ---------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= bus.write_data;
    end
  end

  // ---------------------------------------------------------------------
  // Console TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && bus.tx_ready;
  // When full, a same-cycle pop frees the head slot; wr_ptr == rd_ptr then,
  // so the new byte lands in the slot being consumed this edge.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.write_data[7:0];
    end
  end

  // ---------------------------------------------------------------------
  // CYCLE counter and TOHOST / halt
  // ---------------------------------------------------------------------
  logic [31:0] cycle_cnt;
  logic [31:0] tohost_val;
  logic        halted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cycle_we) begin
      cycle_cnt <= bus.write_data;
    end else if (!halted_q) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tohost_val <= '0;
      halted_q   <= 1'b0;
    end else if (tohost_we) begin
      tohost_val <= bus.write_data;
      halted_q   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------
  logic [31:0] read_data_c;

  always_comb begin
    read_data_c = '0;
    if (ram_hit) begin
      read_data_c = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_CONSOLE: read_data_c = 32'(count);
        REG_STATUS:  read_data_c = {28'd0, overflow, halted_q, fifo_empty, fifo_full};
        REG_CYCLE:   read_data_c = cycle_cnt;
        REG_TOHOST:  read_data_c = tohost_val;
        default:     read_data_c = '0;
      endcase
    end
  end

  assign bus.read_data = read_data_c;
  // Stale storage is masked so tx_data reads 0 whenever the FIFO is empty.
  assign bus.tx_data   = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign bus.tx_valid  = !fifo_empty;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam logic [31:0] CON_A = 32'hFFFF_0000;
  localparam logic [31:0] STA_A = 32'hFFFF_0004;
  localparam logic [31:0] CYC_A = 32'hFFFF_0008;
  localparam logic [31:0] TOH_A = 32'hFFFF_000C;
  localparam logic [31:0] UNM_A = 32'h0008_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .RAM_WORDS (1024),
    .FIFO_DEPTH(8),
    .MMIO_BASE (32'hFFFF_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [31:0] m_ram [1024];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [31:0] m_cycle;
  logic [31:0] m_tohost;
  logic        m_halted;

  // Values sampled in the most recent drive() call (state before its edge)
  logic [31:0] last_rd;
  logic [7:0]  last_txd;
  logic        last_txv;
  logic        last_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] st;
    if (a < 32'h1000) return m_ram[a[11:2]];
    if (a[31:16] == 16'hFFFF) begin
      st = 0;
      st[0] = (m_q.size() == 8);
      st[1] = (m_q.size() == 0);
      st[2] = m_halted;
      st[3] = m_ovf;
      case (a[3:2])
        2'd0: return m_q.size();
        2'd1: return st;
        2'd2: return m_cycle;
        default: return m_tohost;
      endcase
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_cycle = 0;
    m_tohost = 0;
    m_halted = 0;
  endtask

  task automatic model_step(input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic rdy, input logic rst);
    bit is_mmio;
    bit popping;
    if (rst) begin
      model_reset();
      return;
    end
    is_mmio = (a[31:16] == 16'hFFFF);
    popping = (m_q.size() > 0) && rdy;
    if (we && is_mmio && a[3:2] == 2'd2) m_cycle = wd;
    else if (!m_halted) m_cycle = m_cycle + 1;
    if (popping) void'(m_q.pop_front());
    if (we && is_mmio && a[3:2] == 2'd0) begin
      if (m_q.size() < 8) m_q.push_back(wd[7:0]);
      else m_ovf = 1;
    end
    if (we && a < 32'h1000) m_ram[a[11:2]] = wd;
    if (we && is_mmio && a[3:2] == 2'd3) begin
      m_tohost = wd;
      m_halted = 1;
    end
  endtask

  // One bus cycle: drive at negedge, compare all outputs against the model,
  // then advance the model across the rising edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic rdy, input logic rst);
    @(negedge clk);
    bus.addr       = a;
    bus.write_data = wd;
    bus.mem_write  = we;
    bus.tx_ready   = rdy;
    reset          = rst;
    #1;
    last_rd   = bus.read_data;
    last_txd  = bus.tx_data;
    last_txv  = bus.tx_valid;
    last_halt = bus.halted;
    check("read_data", last_rd, model_read(a));
    check("tx_valid", 32'(last_txv), 32'(m_q.size() != 0));
    check("tx_data", 32'(last_txd), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check("halted", 32'(last_halt), 32'(m_halted));
    @(posedge clk);
    model_step(a, wd, we, rdy, rst);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        rdy;
    logic        rst;
    int unsigned r;

    foreach (m_ram[i]) m_ram[i] = 0;
    model_reset();
    reset          = 1'b1;
    bus.addr       = UNM_A;
    bus.write_data = 0;
    bus.mem_write  = 1'b0;
    bus.tx_ready   = 1'b0;

    // Reset and CYCLE count-up
    drive(UNM_A, 0, 0, 0, 1);
    drive(UNM_A, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      drive(CYC_A, 0, 0, 0, 0);
      check("cycle_after_reset", last_rd, k);
      if (k == 0) begin
        check("rst_tx_valid", 32'(last_txv), 0);
        check("rst_halted", 32'(last_halt), 0);
        check("rst_tx_data", 32'(last_txd), 0);
      end
    end
    drive(STA_A, 0, 0, 0, 0);
    check("status_idle", last_rd, 32'h2);
    drive(CYC_A, 32'hFFFF_FFFE, 1, 0, 0);
    drive(CYC_A, 0, 0, 0, 0);
    check("cycle_load", last_rd, 32'hFFFF_FFFE);
    drive(CYC_A, 0, 0, 0, 0);
    check("cycle_max", last_rd, 32'hFFFF_FFFF);
    drive(CYC_A, 0, 0, 0, 0);
    check("cycle_wrap", last_rd, 32'h0);

    // RAM
    drive(32'h10, 32'hDEAD_BEEF, 1, 0, 0);
    drive(32'h10, 0, 0, 0, 0);
    check("ram_raw", last_rd, 32'hDEAD_BEEF);
    drive(32'h13, 0, 0, 0, 0);
    check("ram_lowbits", last_rd, 32'hDEAD_BEEF);
    drive(UNM_A, 0, 0, 0, 0);
    check("unmapped", last_rd, 32'h0);

    // Console ordering
    drive(CON_A, 32'h48, 1, 0, 0);
    drive(CON_A, 32'h69, 1, 0, 0);
    drive(CON_A, 0, 0, 0, 0);
    check("con_count2", last_rd, 2);
    drive(STA_A, 0, 0, 0, 0);
    check("status_nonempty", last_rd, 32'h0);
    drive(STA_A, 0, 0, 1, 0);
    check("tx_first", 32'(last_txd), 32'h48);
    drive(STA_A, 0, 0, 1, 0);
    check("tx_second", 32'(last_txd), 32'h69);
    drive(STA_A, 0, 0, 0, 0);
    check("tx_drained_valid", 32'(last_txv), 0);
    check("status_drained", last_rd, 32'h2);

    // Full / overflow
    for (int i = 0; i < 9; i++) drive(CON_A, 32'hA0 + i, 1, 0, 0);
    drive(STA_A, 0, 0, 0, 0);
    check("status_full_ovf", last_rd, 32'h9);
    drive(CON_A, 0, 0, 0, 0);
    check("con_count_full", last_rd, 8);
    drive(CON_A, 32'hB0, 1, 1, 0);
    check("full_pushpop_head", 32'(last_txd), 32'hA0);
    drive(CON_A, 0, 0, 0, 0);
    check("con_count_still8", last_rd, 8);
    for (int i = 0; i < 8; i++) begin
      drive(STA_A, 0, 0, 1, 0);
      if (i == 7) check("full_last_byte", 32'(last_txd), 32'hB0);
    end
    drive(STA_A, 0, 0, 0, 0);
    check("status_empty_ovf", last_rd, 32'hA);

    // Halt
    drive(CON_A, 32'h5A, 1, 0, 0);
    drive(CYC_A, 32'h100, 1, 0, 0);
    drive(TOH_A, 32'h1, 1, 0, 0);
    drive(TOH_A, 0, 0, 0, 0);
    check("halted_set", 32'(last_halt), 1);
    check("tohost_read", last_rd, 1);
    for (int i = 0; i < 10; i++) begin
      drive(CYC_A, 0, 0, 0, 0);
      check("cycle_frozen", last_rd, 32'h101);
    end
    drive(STA_A, 0, 0, 1, 0);
    check("halt_drain_data", 32'(last_txd), 32'h5A);
    drive(STA_A, 0, 0, 0, 0);
    check("halt_drain_empty", 32'(last_txv), 0);
    check("status_halted", last_rd, 32'hE);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) drive(CON_A, 32'h30 + i, 1, 0, 0);
    drive(CON_A, 32'h55, 1, 0, 1);
    drive(CYC_A, 0, 0, 0, 0);
    check("midrst_cycle", last_rd, 0);
    check("midrst_tx_valid", 32'(last_txv), 0);
    check("midrst_halted", 32'(last_halt), 0);
    drive(CON_A, 0, 0, 0, 0);
    check("midrst_count", last_rd, 0);
    drive(32'h10, 0, 0, 0, 0);
    check("midrst_ram_kept", last_rd, 32'hDEAD_BEEF);
    drive(STA_A, 0, 0, 0, 0);
    check("midrst_status", last_rd, 32'h2);

    // Randomized traffic against the model
    for (int w = 0; w < 16; w++) drive(w * 4, $urandom, 1, 0, 0);
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 99);
      wd = $urandom;
      we = $urandom_range(0, 1) == 1;
      if (r < 40) begin
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      end else if (r < 90) begin
        a = 32'hFFFF_0000 | ($urandom_range(0, 4095) << 4)
          | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        if (a[3:2] == 2'd3 && we && $urandom_range(0, 19) != 0) we = 1'b0;
      end else begin
        a = $urandom;
        if (a < 32'h1000 || a[31:16] == 16'hFFFF) a = UNM_A;
      end
      rdy = $urandom_range(0, 9) < 3;
      rst = $urandom_range(0, 199) == 0;
      drive(a, wd, we, rdy, rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
